fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, single-outstanding imem request,
// IF/ID register with a one-entry hold buffer, redirect/flush and halt.
module fetch_ctrl #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Halt,
    input  logic            Stall,
    output logic            ImemReq,
    output logic [PC_W-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemRvalid,
    input  logic [31:0]     ImemRdata,
    output logic [PC_W-1:0] IfPc,
    output logic [31:0]     IfInstr,
    output logic            IfValid,
    output logic            Flush,
    output logic            Halted
);

    typedef enum logic [1:0] {
        FETCH_REQ,
        WAIT_RSP,
        DROP,
        HALTED
    } state_t;

    state_t          state, state_d;
    logic [PC_W-1:0] pc, pc_d;
    logic [PC_W-1:0] req_pc, req_pc_d;
    logic            hold_v, hold_v_d;
    logic [PC_W-1:0] hold_pc, hold_pc_d;
    logic [31:0]     hold_instr, hold_instr_d;
    logic            halt_pend, halt_pend_d;
    logic [PC_W-1:0] if_pc_d;
    logic [31:0]     if_instr_d;
    logic            if_valid_d;

    logic grant;
    logic deliver;
    logic outstanding;
    logic brpc_unused;

    assign brpc_unused = ^BrPC;

    assign ImemAddr = pc;
    assign Halted   = (state == HALTED);

    always_comb begin
        state_d      = state;
        pc_d         = pc;
        req_pc_d     = req_pc;
        hold_v_d     = hold_v;
        hold_pc_d    = hold_pc;
        hold_instr_d = hold_instr;
        halt_pend_d  = halt_pend;
        if_pc_d      = IfPc;
        if_instr_d   = IfInstr;
        if_valid_d   = IfValid;

        ImemReq = reset && (state == FETCH_REQ) && !hold_v;
        grant   = ImemReq && ImemGnt;
        deliver = (state == WAIT_RSP) && ImemRvalid;
        Flush   = PcSel && (state != HALTED);
        // A response landing in the redirect cycle retires the request.
        outstanding = grant
                   || (((state == WAIT_RSP) || (state == DROP)) && !ImemRvalid);

        if (state == HALTED) begin
            if_valid_d = 1'b0;
        end else if (PcSel) begin
            pc_d        = {BrPC[PC_W-1:2], 2'b00};
            if_valid_d  = 1'b0;
            hold_v_d    = 1'b0;
            halt_pend_d = halt_pend || Halt;
            if (outstanding)
                state_d = DROP;
            else if (halt_pend || Halt)
                state_d = HALTED;
            else
                state_d = FETCH_REQ;
        end else begin
            unique case (state)
                FETCH_REQ: begin
                    if (grant) begin
                        pc_d     = pc + PC_W'(4);
                        req_pc_d = pc;
                        state_d  = WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (ImemRvalid)
                        state_d = FETCH_REQ;
                end
                DROP: begin
                    if (ImemRvalid)
                        state_d = halt_pend ? HALTED : FETCH_REQ;
                end
                default: ;
            endcase

            if (Stall) begin
                if (deliver) begin
                    hold_v_d     = 1'b1;
                    hold_pc_d    = req_pc;
                    hold_instr_d = ImemRdata;
                end
            end else if (hold_v) begin
                if_pc_d    = hold_pc;
                if_instr_d = hold_instr;
                if_valid_d = 1'b1;
                hold_v_d   = 1'b0;
            end else if (deliver) begin
                if_pc_d    = req_pc;
                if_instr_d = ImemRdata;
                if_valid_d = 1'b1;
            end else begin
                if_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH_REQ;
            pc         <= RESET_PC;
            req_pc     <= '0;
            hold_v     <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= '0;
            halt_pend  <= 1'b0;
            IfPc       <= '0;
            IfInstr    <= '0;
            IfValid    <= 1'b0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            req_pc     <= req_pc_d;
            hold_v     <= hold_v_d;
            hold_pc    <= hold_pc_d;
            hold_instr <= hold_instr_d;
            halt_pend  <= halt_pend_d;
            IfPc       <= if_pc_d;
            IfInstr    <= if_instr_d;
            IfValid    <= if_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic
// against a transaction-level model of fetch, redirect and halt.
module tb_fetch_ctrl;

    localparam int PC_W = 9;
    localparam int PC_MOD = 1 << PC_W;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            PcSel = 1'b0;
    logic [31:0]     BrPC = '0;
    logic            Halt = 1'b0;
    logic            Stall = 1'b0;
    logic            ImemGnt = 1'b0;
    logic            ImemRvalid = 1'b0;
    logic [31:0]     ImemRdata = '0;
    logic            ImemReq;
    logic [PC_W-1:0] ImemAddr;
    logic [PC_W-1:0] IfPc;
    logic [31:0]     IfInstr;
    logic            IfValid;
    logic            Flush;
    logic            Halted;

    int vectors = 0;
    int errors = 0;

    typedef struct {
        int          pc;
        logic [31:0] ins;
    } ent_t;

    fetch_ctrl #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .PcSel(PcSel), .BrPC(BrPC),
        .Halt(Halt), .Stall(Stall), .ImemReq(ImemReq),
        .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata),
        .IfPc(IfPc), .IfInstr(IfInstr), .IfValid(IfValid),
        .Flush(Flush), .Halted(Halted)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        PcSel = 0; BrPC = '0; Halt = 0; Stall = 0;
        ImemGnt = 0; ImemRvalid = 0; ImemRdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        ImemGnt = 1;
        cyc();
        cyc();
        vectors++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", ImemReq); end
        vectors++; if (ImemAddr !== 9'h000) begin errors++; $display("FAIL rst_addr got %h want 000", ImemAddr); end
        vectors++; if (IfValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", IfValid); end
        vectors++; if (IfPc !== 9'h000) begin errors++; $display("FAIL rst_ifpc got %h want 000", IfPc); end
        vectors++; if (IfInstr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", IfInstr); end
        vectors++; if (Halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", Halted); end
    endtask

    task automatic test_seq();
        logic [PC_W-1:0] a;
        logic [31:0] d;
        reset = 1;
        ImemGnt = 1;
        for (int k = 0; k < 4; k++) begin
            a = PC_W'(4 * k);
            d = 32'hA500_0000 + k;
            #1;
            vectors++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL seq_req got %b want 1", ImemReq); end
            vectors++; if (ImemAddr !== a) begin errors++; $display("FAIL seq_addr got %h want %h", ImemAddr, a); end
            cyc();
            ImemGnt = 0; ImemRvalid = 1; ImemRdata = d;
            #1;
            vectors++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL seq_wait_req got %b want 0", ImemReq); end
            cyc();
            ImemRvalid = 0; ImemGnt = 1;
            vectors++; if (IfPc !== a) begin errors++; $display("FAIL seq_ifpc got %h want %h", IfPc, a); end
            vectors++; if (IfInstr !== d) begin errors++; $display("FAIL seq_instr got %h want %h", IfInstr, d); end
            vectors++; if (IfValid !== 1'b1) begin errors++; $display("FAIL seq_valid got %b want 1", IfValid); end
        end
    endtask

    task automatic test_stall();
        Stall = 1;
        #1;
        vectors++; if (ImemAddr !== 9'h010) begin errors++; $display("FAIL stall_addr got %h want 010", ImemAddr); end
        cyc();
        ImemGnt = 0; ImemRvalid = 1; ImemRdata = 32'h5757_0010;
        cyc();
        ImemRvalid = 0; ImemGnt = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL stall_req got %b want 0", ImemReq); end
            vectors++; if (IfPc !== 9'h00C) begin errors++; $display("FAIL stall_ifpc got %h want 00c", IfPc); end
            vectors++; if (IfInstr !== 32'hA500_0003) begin errors++; $display("FAIL stall_instr got %h want a5000003", IfInstr); end
            vectors++; if (IfValid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", IfValid); end
            cyc();
        end
        Stall = 0;
        #1;
        vectors++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL drain_req got %b want 0", ImemReq); end
        cyc();
        vectors++; if (IfPc !== 9'h010) begin errors++; $display("FAIL drain_ifpc got %h want 010", IfPc); end
        vectors++; if (IfInstr !== 32'h5757_0010) begin errors++; $display("FAIL drain_instr got %h want 57570010", IfInstr); end
        vectors++; if (IfValid !== 1'b1) begin errors++; $display("FAIL drain_valid got %b want 1", IfValid); end
        vectors++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL drain_req2 got %b want 1", ImemReq); end
        vectors++; if (ImemAddr !== 9'h014) begin errors++; $display("FAIL drain_addr got %h want 014", ImemAddr); end
    endtask

    task automatic test_redirect();
        Stall = 1;
        cyc();
        ImemGnt = 0; PcSel = 1; BrPC = 32'h40;
        #1;
        vectors++; if (Flush !== 1'b1) begin errors++; $display("FAIL redir_flush got %b want 1", Flush); end
        vectors++; if (IfValid !== 1'b1) begin errors++; $display("FAIL redir_pre_valid got %b want 1", IfValid); end
        cyc();
        PcSel = 0;
        vectors++; if (IfValid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", IfValid); end
        vectors++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL redir_drop_req got %b want 0", ImemReq); end
        ImemRvalid = 1; ImemRdata = 32'hDEAD_BEEF; Stall = 0;
        cyc();
        ImemRvalid = 0;
        vectors++; if (IfValid !== 1'b0) begin errors++; $display("FAIL redir_stale_valid got %b want 0", IfValid); end
        vectors++; if (IfInstr !== 32'h5757_0010) begin errors++; $display("FAIL redir_stale_instr got %h want 57570010", IfInstr); end
        vectors++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL redir_req got %b want 1", ImemReq); end
        vectors++; if (ImemAddr !== 9'h040) begin errors++; $display("FAIL redir_addr got %h want 040", ImemAddr); end
    endtask

    task automatic test_wrap();
        PcSel = 1; BrPC = 32'h1FC;
        cyc();
        PcSel = 0;
        vectors++; if (ImemAddr !== 9'h1FC) begin errors++; $display("FAIL wrap_top got %h want 1fc", ImemAddr); end
        ImemGnt = 1;
        cyc();
        ImemGnt = 0;
        vectors++; if (ImemAddr !== 9'h000) begin errors++; $display("FAIL wrap_addr got %h want 000", ImemAddr); end
        ImemRvalid = 1; ImemRdata = 32'h1FC0_0001;
        cyc();
        ImemRvalid = 0;
        vectors++; if (IfPc !== 9'h1FC) begin errors++; $display("FAIL wrap_ifpc got %h want 1fc", IfPc); end
        vectors++; if (IfValid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", IfValid); end
        PcSel = 1; BrPC = 32'h0000_0213;
        cyc();
        PcSel = 0;
        vectors++; if (ImemAddr !== 9'h010) begin errors++; $display("FAIL align_addr got %h want 010", ImemAddr); end
        vectors++; if (IfValid !== 1'b0) begin errors++; $display("FAIL align_valid got %b want 0", IfValid); end
    endtask

    task automatic test_halt();
        PcSel = 1; Halt = 1; BrPC = 32'h1C;
        #1;
        vectors++; if (Flush !== 1'b1) begin errors++; $display("FAIL halt_flush got %b want 1", Flush); end
        vectors++; if (Halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b want 0", Halted); end
        cyc();
        PcSel = 0; Halt = 0;
        vectors++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_halted got %b want 1", Halted); end
        vectors++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL halt_req got %b want 0", ImemReq); end
        vectors++; if (IfValid !== 1'b0) begin errors++; $display("FAIL halt_valid got %b want 0", IfValid); end
        PcSel = 1; BrPC = 32'h80; ImemGnt = 1; Stall = 1;
        #1;
        vectors++; if (Flush !== 1'b0) begin errors++; $display("FAIL halt_noflush got %b want 0", Flush); end
        vectors++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL halt_req2 got %b want 0", ImemReq); end
        cyc();
        vectors++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_stay got %b want 1", Halted); end
        vectors++; if (ImemAddr !== 9'h01C) begin errors++; $display("FAIL halt_pc got %h want 01c", ImemAddr); end
        clear_inputs();
    endtask

    task automatic test_reset_midflight();
        reset = 0;
        #1;
        vectors++; if (Halted !== 1'b0) begin errors++; $display("FAIL mid_unhalt got %b want 0", Halted); end
        cyc();
        reset = 1; ImemGnt = 1;
        cyc();
        ImemGnt = 0;
        vectors++; if (ImemAddr !== 9'h004) begin errors++; $display("FAIL mid_pre_addr got %h want 004", ImemAddr); end
        reset = 0;
        #1;
        vectors++; if (ImemAddr !== 9'h000) begin errors++; $display("FAIL mid_rst_addr got %h want 000", ImemAddr); end
        vectors++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b want 0", ImemReq); end
        cyc();
        reset = 1; ImemRvalid = 1; ImemRdata = 32'hBAD0_0000;
        cyc();
        ImemRvalid = 0;
        vectors++; if (IfValid !== 1'b0) begin errors++; $display("FAIL late_valid got %b want 0", IfValid); end
        vectors++; if (IfInstr !== 32'h0) begin errors++; $display("FAIL late_instr got %h want 0", IfInstr); end
        vectors++; if (ImemReq !== 1'b1) begin errors++; $display("FAIL late_req got %b want 1", ImemReq); end
        vectors++; if (ImemAddr !== 9'h000) begin errors++; $display("FAIL late_addr got %h want 000", ImemAddr); end
    endtask

    task automatic test_random();
        int          m_pc, pend_addr, if_pc, mem_cnt, halt_age;
        bit          pend, pend_drop, halt_pend, halted, if_valid;
        bit          mem_busy, grant, exp_req, dlv, to_halt;
        logic [31:0] if_instr, mem_data;
        ent_t        bq[$];
        ent_t        e;
        clear_inputs();
        reset = 0;
        cyc();
        reset = 1;
        m_pc = 0; pend = 0; pend_drop = 0; pend_addr = 0; halt_pend = 0;
        halted = 0; if_pc = 0; if_instr = '0; if_valid = 0; bq.delete();
        mem_busy = 0; mem_cnt = 0; mem_data = '0; halt_age = 0;
        for (int n = 0; n < 4000; n++) begin
            if ((n % 300) == 299 || halt_age > 6) begin
                clear_inputs();
                reset = 0;
                m_pc = 0; pend = 0; halt_pend = 0; halted = 0;
                if_pc = 0; if_instr = '0; if_valid = 0; bq.delete();
                halt_age = 0;
                #1;
                vectors++; if (ImemReq !== 1'b0) begin errors++; $display("FAIL rnd_rst_req got %b want 0", ImemReq); end
                vectors++; if (ImemAddr !== 9'h000) begin errors++; $display("FAIL rnd_rst_addr got %h want 000", ImemAddr); end
                vectors++; if (IfValid !== 1'b0) begin errors++; $display("FAIL rnd_rst_valid got %b want 0", IfValid); end
                cyc();
                reset = 1;
                continue;
            end
            Stall = ($urandom % 4) == 0;
            ImemRvalid = mem_busy && (mem_cnt == 0);
            ImemRdata = ImemRvalid ? mem_data : $urandom;
            ImemGnt = !mem_busy && (($urandom % 3) != 0);
            PcSel = !ImemRvalid && (($urandom % 10) == 0);
            Halt = PcSel && (($urandom % 8) == 0);
            BrPC = $urandom;
            #1;
            exp_req = !halted && !pend && bq.size() == 0;
            vectors++; if (ImemReq !== exp_req) begin errors++; $display("FAIL rnd_req n=%0d got %b want %b", n, ImemReq, exp_req); end
            vectors++; if (ImemAddr !== PC_W'(m_pc)) begin errors++; $display("FAIL rnd_addr n=%0d got %h want %h", n, ImemAddr, PC_W'(m_pc)); end
            vectors++; if (Flush !== (PcSel && !halted)) begin errors++; $display("FAIL rnd_flush n=%0d got %b want %b", n, Flush, PcSel && !halted); end
            vectors++; if (Halted !== halted) begin errors++; $display("FAIL rnd_halted n=%0d got %b want %b", n, Halted, halted); end
            grant = exp_req && ImemGnt;
            if (!halted) begin
                dlv = 0; to_halt = 0;
                if (ImemRvalid && pend) begin
                    pend = 0;
                    if (!pend_drop) begin
                        dlv = 1; e.pc = pend_addr; e.ins = ImemRdata;
                    end else if (halt_pend) begin
                        to_halt = 1;
                    end
                end
                if (PcSel) begin
                    if (grant) begin pend = 1; pend_addr = m_pc; end
                    if (pend) pend_drop = 1;
                    m_pc = int'(BrPC % PC_MOD) & 32'h1FC;
                    if_valid = 0;
                    bq.delete();
                    halt_pend = halt_pend || Halt;
                    if (!pend && halt_pend) to_halt = 1;
                end else begin
                    if (grant) begin
                        pend = 1; pend_drop = 0; pend_addr = m_pc;
                        m_pc = (m_pc + 4) % PC_MOD;
                    end
                    if (Stall) begin
                        if (dlv) bq.push_back(e);
                    end else if (bq.size() > 0) begin
                        e = bq.pop_front();
                        if_pc = e.pc; if_instr = e.ins; if_valid = 1;
                    end else if (dlv) begin
                        if_pc = e.pc; if_instr = e.ins; if_valid = 1;
                    end else begin
                        if_valid = 0;
                    end
                end
                if (to_halt) halted = 1;
            end
            if (ImemRvalid) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (grant) begin
                mem_busy = 1; mem_cnt = $urandom % 3; mem_data = $urandom;
            end
            halt_age = halted ? halt_age + 1 : 0;
            cyc();
            vectors++; if (IfValid !== if_valid) begin errors++; $display("FAIL rnd_valid n=%0d got %b want %b", n, IfValid, if_valid); end
            vectors++; if (IfPc !== PC_W'(if_pc)) begin errors++; $display("FAIL rnd_ifpc n=%0d got %h want %h", n, IfPc, PC_W'(if_pc)); end
            vectors++; if (IfInstr !== if_instr) begin errors++; $display("FAIL rnd_instr n=%0d got %h want %h", n, IfInstr, if_instr); end
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
